regdst_write_arbiter: RTL

- Shares the single register-file write-address path, the 5-bit 2:1 destination mux, between two writeback requesters: A (ALU writeback) and B (load/multicycle unit).
- Sequences the mux select with a registered round-robin grant FSM and a bounded hold time.
- Presents the selected 5-bit destination address and a write enable to the register file.
- Suppresses writes to register 0, which is hardwired to zero.

---
 rtl/regdst_write_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/regdst_write_arbiter.sv
// Round-robin arbiter sharing the register-file write-address mux between ALU (A) and load unit (B).
// Grant one cycle after request; the loser waits at most MAX_HOLD cycles; writes to r0 are dropped.
module regdst_write_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  state_t           nxt_state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic             last_b;
  logic             nxt_last_b;

  always_comb begin
    nxt_state  = state;
    nxt_cnt    = hold_cnt;
    nxt_last_b = last_b;
    case (state)
      IDLE: begin
        nxt_cnt = '0;
        // On a tie, last_b set means A has not had the most recent turn.
        if (req_a && (!req_b || last_b))
          nxt_state = OWN_A;
        else if (req_b)
          nxt_state = OWN_B;
      end
      OWN_A: begin
        if (!req_a || (req_b && hold_cnt == HOLD_LAST)) begin
          nxt_last_b = 1'b0;
          nxt_cnt    = '0;
          nxt_state  = req_b ? OWN_B : IDLE;
        end else if (hold_cnt != HOLD_LAST) begin
          nxt_cnt = hold_cnt + 1'b1;
        end
      end
      OWN_B: begin
        if (!req_b || (req_a && hold_cnt == HOLD_LAST)) begin
          nxt_last_b = 1'b1;
          nxt_cnt    = '0;
          nxt_state  = req_a ? OWN_A : IDLE;
        end else if (hold_cnt != HOLD_LAST) begin
          nxt_cnt = hold_cnt + 1'b1;
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last_b   <= 1'b1;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      sel      <= 1'b0;
    end else begin
      state    <= nxt_state;
      hold_cnt <= nxt_cnt;
      last_b   <= nxt_last_b;
      gnt_a    <= (nxt_state == OWN_A);
      gnt_b    <= (nxt_state == OWN_B);
      // sel keeps its last value while idle so the mux does not toggle needlessly.
      if (nxt_state == OWN_A)
        sel <= 1'b0;
      else if (nxt_state == OWN_B)
        sel <= 1'b1;
    end
  end

  assign wr_addr = sel ? addr_b : addr_a;
  assign wr_en   = ((gnt_a & req_a) | (gnt_b & req_b)) & (wr_addr != '0);

endmodule
